// File: rtl/spi_periph_pkg.sv
// Shared definitions for the system-clocked SPI/QSPI RAM peripheral:
// opcodes, FSM states and the per-command configuration decoded from the opcode.
package spi_periph_pkg;

    localparam logic [7:0] CMD_READ    = 8'h03;
    localparam logic [7:0] CMD_FAST    = 8'h0B;
    localparam logic [7:0] CMD_WRITE   = 8'h02;
    localparam logic [7:0] CMD_QREAD   = 8'h6B;
    localparam logic [7:0] CMD_QWRITE  = 8'h32;
    localparam logic [7:0] CMD_QIOREAD = 8'hEB;

    typedef enum logic [2:0] {
        CMD,
        ADDR,
        DUMMY,
        READ,
        WRITE,
        IGNORE
    } state_t;

    typedef enum logic [1:0] {
        DUMMY_NONE,
        DUMMY_FAST,
        DUMMY_QUAD
    } dummy_sel_t;

    // How the rest of a transaction is clocked once the opcode is known.
    typedef struct packed {
        logic       quad_addr;
        logic       quad_data;
        logic       write;
        dummy_sel_t dummy;
    } cmd_cfg_t;

    function automatic logic cmd_supported(input logic [7:0] op);
        return op inside {CMD_READ, CMD_FAST, CMD_WRITE, CMD_QREAD, CMD_QWRITE, CMD_QIOREAD};
    endfunction

    function automatic cmd_cfg_t decode_cmd(input logic [7:0] op);
        cmd_cfg_t cfg;
        cfg = '{quad_addr: 1'b0, quad_data: 1'b0, write: 1'b0, dummy: DUMMY_NONE};
        case (op)
            CMD_FAST:    cfg.dummy = DUMMY_FAST;
            CMD_WRITE:   cfg.write = 1'b1;
            CMD_QREAD:   begin cfg.quad_data = 1'b1; cfg.dummy = DUMMY_QUAD; end
            CMD_QWRITE:  begin cfg.quad_data = 1'b1; cfg.write = 1'b1; end
            CMD_QIOREAD: begin cfg.quad_addr = 1'b1; cfg.quad_data = 1'b1; cfg.dummy = DUMMY_QUAD; end
            default:     ;
        endcase
        return cfg;
    endfunction

endpackage

// File: rtl/spi_pin_sync.sv
// Two-flop synchroniser for the whole SPI pad bundle plus SCK edge detection.
// Select resets to "deselected" so the core starts idle.
module spi_pin_sync (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       spi_clk,
    input  logic       spi_select,
    input  logic [3:0] spi_d_in,
    output logic       sck_rise,
    output logic       sck_fall,
    output logic       deselect,
    output logic [3:0] d_sync
);

    logic       sck_meta, sck_sync, sck_prev;
    logic       sel_meta, sel_sync;
    logic [3:0] d_meta;

    // Double-register every pad and keep one extra SCK history bit for edge detection.
    // NOTE: clocked state uses <= so every flop samples the pre-edge value of its source.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sck_meta <= 1'b0;
            sck_sync <= 1'b0;
            sck_prev <= 1'b0;
            sel_meta <= 1'b1;
            sel_sync <= 1'b1;
            d_meta   <= '0;
            d_sync   <= '0;
        end else begin
            sck_meta <= spi_clk;
            sck_sync <= sck_meta;
            sck_prev <= sck_sync;
            sel_meta <= spi_select;
            sel_sync <= sel_meta;
            d_meta   <= spi_d_in;
            d_sync   <= d_meta;
        end
    end

    assign sck_rise = sck_sync & ~sck_prev;
    assign sck_fall = ~sck_sync & sck_prev;
    assign deselect = sel_sync;

endmodule

// File: rtl/qspi_ram_peripheral.sv
// SPI/QSPI RAM slave running entirely on the system clock. Pads are oversampled;
// SCK rising edges sample, falling edges shift read data out.
module qspi_ram_peripheral
    import spi_periph_pkg::*;
#(
    parameter int RAM_LEN_BITS = 6,
    parameter int ADDR_BITS    = 24,
    parameter int FAST_DUMMY   = 8,
    parameter int QUAD_DUMMY   = 2
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    spi_clk,
    input  logic                    spi_select,
    input  logic [3:0]              spi_d_in,
    output logic [3:0]              spi_d_out,
    output logic [3:0]              spi_d_oe,
    input  logic [RAM_LEN_BITS-1:0] debug_addr,
    output logic [7:0]              debug_data
);

    localparam int CNT_W     = $clog2(ADDR_BITS + FAST_DUMMY + QUAD_DUMMY + 8);
    localparam int RAM_DEPTH = 2 ** RAM_LEN_BITS;

    logic       sck_rise, sck_fall, deselect;
    logic [3:0] d_sync;

    spi_pin_sync u_sync (
        .clk        (clk),
        .rst_n      (rst_n),
        .spi_clk    (spi_clk),
        .spi_select (spi_select),
        .spi_d_in   (spi_d_in),
        .sck_rise   (sck_rise),
        .sck_fall   (sck_fall),
        .deselect   (deselect),
        .d_sync     (d_sync)
    );

    state_t                  state, state_next;
    cmd_cfg_t                cfg, cmd_dec;
    logic [CNT_W-1:0]        cnt, dummy_len;
    logic [7:0]              sreg, out_sh, fetch_byte, rd_src;
    logic [7:0]              shift_single, shift_quad;
    logic [ADDR_BITS-1:0]    addr_sh, addr_next;
    logic [RAM_LEN_BITS-1:0] ptr;
    logic                    wr_pend;
    logic                    cmd_last, addr_last, dummy_last, byte_last;
    logic [7:0]              mem [RAM_DEPTH];

    // Decode helpers derived from the current counters and the incoming pad sample.
    // NOTE: every always_comb output is defaulted first so no path can infer a latch.
    always_comb begin
        shift_single = {sreg[6:0], d_sync[0]};
        shift_quad   = {sreg[3:0], d_sync};
        cmd_dec      = decode_cmd(shift_single);
        addr_next    = cfg.quad_addr ? ((addr_sh << 4) | ADDR_BITS'(d_sync))
                                     : ((addr_sh << 1) | ADDR_BITS'(d_sync[0]));
        dummy_len    = '0;
        case (cfg.dummy)
            DUMMY_FAST: dummy_len = CNT_W'(FAST_DUMMY);
            DUMMY_QUAD: dummy_len = CNT_W'(QUAD_DUMMY);
            default:    dummy_len = '0;
        endcase
        cmd_last   = (cnt == CNT_W'(7));
        addr_last  = cfg.quad_addr ? (cnt == CNT_W'(ADDR_BITS / 4 - 1))
                                   : (cnt == CNT_W'(ADDR_BITS - 1));
        dummy_last = (cnt == dummy_len - CNT_W'(1));
        byte_last  = cfg.quad_data ? (cnt == CNT_W'(1)) : (cnt == CNT_W'(7));
        // A commit pending this clk targets ptr, so the fetch sees the new byte.
        fetch_byte = wr_pend ? sreg : mem[ptr];
        rd_src     = (cnt == '0) ? fetch_byte : out_sh;
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= CMD;
        else        state <= state_next;
    end

    // Next-state logic; deselect overrides any simultaneous SCK event.
    always_comb begin
        state_next = state;
        if (deselect) begin
            state_next = CMD;
        end else if (sck_rise) begin
            case (state)
                CMD:   if (cmd_last) state_next = cmd_supported(shift_single) ? ADDR : IGNORE;
                ADDR:  if (addr_last) begin
                           if (cfg.write)              state_next = WRITE;
                           else if (dummy_len == '0)   state_next = READ;
                           else                        state_next = DUMMY;
                       end
                DUMMY: if (dummy_last) state_next = READ;
                default: ;
            endcase
        end
    end

    // Datapath: shifting on sample events, pad drive on shift events, write commit and ptr.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt       <= '0;
            cfg       <= '{quad_addr: 1'b0, quad_data: 1'b0, write: 1'b0, dummy: DUMMY_NONE};
            sreg      <= '0;
            out_sh    <= '0;
            addr_sh   <= '0;
            ptr       <= '0;
            wr_pend   <= 1'b0;
            spi_d_out <= '0;
            spi_d_oe  <= '0;
        end else begin
            wr_pend <= 1'b0;
            if (wr_pend) ptr <= ptr + RAM_LEN_BITS'(1);

            if (deselect) begin
                cnt       <= '0;
                spi_d_out <= '0;
                spi_d_oe  <= '0;
            end else if (sck_rise) begin
                case (state)
                    CMD: begin
                        sreg <= shift_single;
                        if (cmd_last) begin
                            cnt <= '0;
                            cfg <= cmd_dec;
                        end else begin
                            cnt <= cnt + CNT_W'(1);
                        end
                    end
                    ADDR: begin
                        addr_sh <= addr_next;
                        if (addr_last) begin
                            cnt <= '0;
                            ptr <= addr_next[RAM_LEN_BITS-1:0];
                        end else begin
                            cnt <= cnt + CNT_W'(1);
                        end
                    end
                    DUMMY: cnt <= dummy_last ? '0 : cnt + CNT_W'(1);
                    WRITE: begin
                        sreg <= cfg.quad_data ? shift_quad : shift_single;
                        if (byte_last) begin
                            cnt     <= '0;
                            wr_pend <= 1'b1;
                        end else begin
                            cnt <= cnt + CNT_W'(1);
                        end
                    end
                    default: ;
                endcase
            end else if (sck_fall && state == READ) begin
                spi_d_oe <= cfg.quad_data ? 4'b1111 : 4'b0010;
                if (cfg.quad_data) begin
                    spi_d_out <= rd_src[7:4];
                    out_sh    <= rd_src << 4;
                end else begin
                    spi_d_out <= {2'b00, rd_src[7], 1'b0};
                    out_sh    <= rd_src << 1;
                end
                if (byte_last) begin
                    cnt <= '0;
                    ptr <= ptr + RAM_LEN_BITS'(1);
                end else begin
                    cnt <= cnt + CNT_W'(1);
                end
            end
        end
    end

    // RAM write port: commits the assembled byte one clk after its last sample.
    // NOTE: the array has no reset; contents survive rst_n and map cleanly onto RAM primitives.
    always_ff @(posedge clk) begin
        if (wr_pend) mem[ptr] <= sreg;
    end

    // Registered debug read port; a same-clk SPI write is seen one clk later.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) debug_data <= '0;
        else        debug_data <= mem[debug_addr];
    end

endmodule

// File: tb/tb_qspi_ram_peripheral.sv
// Directed bench for qspi_ram_peripheral: table-driven write/read transactions
// over every opcode plus hand-written abort, ignore and reset sequences.
module tb_qspi_ram_peripheral;

    localparam int HALF = 60;   // SCK half period in ns (6 clk)

    logic       clk, rst_n, spi_clk, spi_select;
    logic [3:0] spi_d_in, spi_d_out, spi_d_oe;
    logic [5:0] debug_addr;
    logic [7:0] debug_data;

    qspi_ram_peripheral dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .spi_clk    (spi_clk),
        .spi_select (spi_select),
        .spi_d_in   (spi_d_in),
        .spi_d_out  (spi_d_out),
        .spi_d_oe   (spi_d_oe),
        .debug_addr (debug_addr),
        .debug_data (debug_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [7:0]  op;
        logic [23:0] addr;
        logic [15:0] data;
    } xfer_t;

    typedef struct {
        logic [5:0] addr;
        logic [7:0] data;
    } dbg_vec_t;

    int         n_tests = 0;
    int         n_fail  = 0;
    logic [3:0] smp_q, smp_oe, oe_seen;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, got, exp);
        end
    endtask

    // One SCK period: data set up while low, outputs sampled just before the rise.
    task automatic sck_cycle(input logic [3:0] d);
        spi_d_in = d;
        #(HALF);
        smp_q   = spi_d_out;
        smp_oe  = spi_d_oe;
        oe_seen = oe_seen | spi_d_oe;
        spi_clk = 1'b1;
        #(HALF);
        spi_clk = 1'b0;
    endtask

    task automatic send_single(input logic [31:0] val, input int nbits);
        for (int i = nbits - 1; i >= 0; i--) sck_cycle({3'b000, val[i]});
    endtask

    task automatic send_quad(input logic [31:0] val, input int nnib);
        for (int i = nnib - 1; i >= 0; i--) sck_cycle(val[4*i +: 4]);
    endtask

    task automatic cs_low;
        spi_select = 1'b0;
        oe_seen    = '0;
        #(HALF);
    endtask

    task automatic cs_high;
        spi_select = 1'b1;
        #100;
    endtask

    task automatic do_write(input xfer_t t);
        cs_low();
        send_single(32'(t.op), 8);
        send_single(32'(t.addr), 24);
        if (t.op == 8'h32) send_quad(32'(t.data), 4);
        else               send_single(32'(t.data), 16);
        cs_high();
    endtask

    // Reads two bytes; reports data, oe seen before data, and AND/OR of oe during data.
    task automatic do_read(input xfer_t t, output logic [15:0] got, output logic [3:0] pre_oe,
                           output logic [3:0] oe_and, output logic [3:0] oe_or);
        logic quad;
        int   ndummy;
        quad   = (t.op == 8'h6B) || (t.op == 8'hEB);
        ndummy = (t.op == 8'h0B) ? 8 : (quad ? 2 : 0);
        cs_low();
        send_single(32'(t.op), 8);
        if (t.op == 8'hEB) send_quad(32'(t.addr), 6);
        else               send_single(32'(t.addr), 24);
        for (int i = 0; i < ndummy; i++) sck_cycle(4'h0);
        pre_oe = oe_seen;
        oe_and = 4'hF;
        oe_or  = 4'h0;
        got    = '0;
        for (int i = 0; i < (quad ? 4 : 16); i++) begin
            sck_cycle(4'h0);
            got    = quad ? {got[11:0], smp_q} : {got[14:0], smp_q[1]};
            oe_and = oe_and & smp_oe;
            oe_or  = oe_or | smp_oe;
        end
        cs_high();
    endtask

    task automatic dbg_check(input string name, input logic [5:0] a, input logic [7:0] exp);
        @(negedge clk);
        debug_addr = a;
        @(posedge clk);
        #1;
        check(name, 32'(debug_data), 32'(exp));
        #6;
    endtask

    initial begin
        xfer_t      wr_tab[4];
        xfer_t      rd_tab[4];
        dbg_vec_t   dbg_tab[8];
        logic [15:0] got;
        logic [3:0]  pre_oe, oe_and, oe_or, exp_oe;

        wr_tab[0] = '{op: 8'h02, addr: 24'h000005, data: 16'hA53C};
        wr_tab[1] = '{op: 8'h32, addr: 24'h00003F, data: 16'h1234};
        wr_tab[2] = '{op: 8'h02, addr: 24'h000010, data: 16'h7788};
        wr_tab[3] = '{op: 8'h02, addr: 24'h000001, data: 16'hC900};

        rd_tab[0] = '{op: 8'h03, addr: 24'h000005, data: 16'hA53C};
        rd_tab[1] = '{op: 8'h6B, addr: 24'h00003F, data: 16'h1234};
        rd_tab[2] = '{op: 8'hEB, addr: 24'h000010, data: 16'h7788};
        rd_tab[3] = '{op: 8'h0B, addr: 24'h000001, data: 16'hC900};

        dbg_tab[0] = '{addr: 6'h05, data: 8'hA5};
        dbg_tab[1] = '{addr: 6'h06, data: 8'h3C};
        dbg_tab[2] = '{addr: 6'h3F, data: 8'h12};
        dbg_tab[3] = '{addr: 6'h00, data: 8'h34};
        dbg_tab[4] = '{addr: 6'h10, data: 8'h77};
        dbg_tab[5] = '{addr: 6'h11, data: 8'h88};
        dbg_tab[6] = '{addr: 6'h01, data: 8'hC9};
        dbg_tab[7] = '{addr: 6'h02, data: 8'h00};

        rst_n      = 1'b0;
        spi_clk    = 1'b0;
        spi_select = 1'b1;
        spi_d_in   = '0;
        debug_addr = '0;
        oe_seen    = '0;
        #22;
        check("reset d_out", 32'(spi_d_out), 32'h0);
        check("reset d_oe", 32'(spi_d_oe), 32'h0);
        check("reset debug_data", 32'(debug_data), 32'h0);
        #20;
        rst_n = 1'b1;
        #100;

        for (int i = 0; i < 4; i++) do_write(wr_tab[i]);

        // Debug port latency: new address shows after exactly one clk.
        dbg_check("dbg addr5", 6'h05, 8'hA5);
        @(negedge clk);
        debug_addr = 6'h06;
        #1;
        check("dbg latency hold", 32'(debug_data), 32'hA5);
        @(posedge clk);
        #1;
        check("dbg addr6", 32'(debug_data), 32'h3C);
        #6;

        for (int i = 0; i < 4; i++) begin
            do_read(rd_tab[i], got, pre_oe, oe_and, oe_or);
            exp_oe = (rd_tab[i].op == 8'h6B || rd_tab[i].op == 8'hEB) ? 4'hF : 4'h2;
            check($sformatf("rd%0d op%0h pre-data oe", i, rd_tab[i].op), 32'(pre_oe), 32'h0);
            check($sformatf("rd%0d op%0h byte0", i, rd_tab[i].op), 32'(got[15:8]), 32'(rd_tab[i].data[15:8]));
            check($sformatf("rd%0d op%0h byte1", i, rd_tab[i].op), 32'(got[7:0]), 32'(rd_tab[i].data[7:0]));
            check($sformatf("rd%0d op%0h data oe", i, rd_tab[i].op), 32'({oe_and, oe_or}), 32'({exp_oe, exp_oe}));
        end

        // Write to addr 2 aborted after 5 data bits leaves the old byte.
        cs_low();
        send_single(32'h02, 8);
        send_single(32'h000002, 24);
        send_single(32'h1F, 5);
        cs_high();
        dbg_check("abort write ram[2]", 6'h02, 8'h00);

        // Deselect mid-read releases the pins within 3 clk.
        cs_low();
        send_single(32'h03, 8);
        send_single(32'h000005, 24);
        for (int i = 0; i < 3; i++) sck_cycle(4'h0);
        check("mid-read oe active", 32'(smp_oe), 32'h2);
        spi_select = 1'b1;
        #30;
        check("deselect oe release", 32'(spi_d_oe), 32'h0);
        #70;

        // Unknown opcode: nothing driven for 40 SCK cycles.
        cs_low();
        send_single(32'h9F, 8);
        for (int i = 0; i < 40; i++) sck_cycle(4'hF);
        check("ignore oe", 32'(oe_seen), 32'h0);
        cs_high();

        // Reset in the middle of a quad read.
        cs_low();
        send_single(32'h6B, 8);
        send_single(32'h00003F, 24);
        sck_cycle(4'h0);
        sck_cycle(4'h0);
        sck_cycle(4'h0);
        check("pre-reset nibble/oe", 32'({smp_q, smp_oe}), 32'h1F);
        #40;
        rst_n = 1'b0;
        #1;
        check("async reset outputs", 32'({spi_d_out, spi_d_oe}), 32'h0);
        check("async reset debug", 32'(debug_data), 32'h0);
        #9;
        spi_select = 1'b1;
        #20;
        rst_n = 1'b1;
        #100;
        do_read(rd_tab[0], got, pre_oe, oe_and, oe_or);
        check("post-reset read data", 32'(got), 32'hA53C);
        check("post-reset read oe", 32'({pre_oe, oe_and, oe_or}), 32'h022);

        for (int i = 0; i < 8; i++)
            dbg_check($sformatf("dbg ram[%0h]", dbg_tab[i].addr), dbg_tab[i].addr, dbg_tab[i].data);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/qspi_ram_peripheral.md
Name: qspi_ram_peripheral

Overview:
- System-clocked SPI/QSPI RAM peripheral, the parametrised successor of our spi_clk-domain RAM slave.
- All SPI pins are oversampled on one system clock. No logic runs on the SPI clock, so the block is safe under a single-clock flow.
- Supports single, dual-dummy fast and quad read/write commands, including quad-I/O (address in quad), with configurable RAM depth, address width and dummy counts.
- Sits between the chip pads and the debug readback path.

Parameters:
- RAM_LEN_BITS, 6: RAM holds 2**RAM_LEN_BITS bytes.
- ADDR_BITS, 24: address bits sent on the bus; must be a multiple of 4 and >= RAM_LEN_BITS.
- FAST_DUMMY, 8: dummy SCK cycles for 0Bh.
- QUAD_DUMMY, 2: dummy SCK cycles for 6Bh/EBh; must be >= 1.

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- spi_clk  in  1  SPI SCK pad, mode 0, asynchronous to clk
- spi_select  in  1  chip select pad; high = deselected
- spi_d_in  in  4  D3..D0 pads; D0 = MOSI in single mode
- spi_d_out  out  4  output data; D1 = MISO in single mode
- spi_d_oe  out  4  per-pin output enable
- debug_addr  in  RAM_LEN_BITS  debug read address
- debug_data  out  8  registered debug read data

Behaviour:
- Reset values: spi_d_out=0, spi_d_oe=0, debug_data=0, state=CMD, all counters 0. RAM contents are not reset.
- Synchronisation:
  - spi_clk, spi_select and spi_d_in each pass through 2 flops.
  - Rising edge of synced SCK = sample event. Falling edge = shift event.
- Timing:
  - SCK high and low phases must each be >= 4 clk periods.
  - Outputs update 1 clk after the shift event, i.e. <= 4 clk after the pad falling edge.
- Deselect:
  - Synced spi_select high forces state CMD, spi_d_oe=0 and bit counter 0 on the same clk.
  - Deselect wins over a simultaneous sample or shift event.
- States and transitions:
  - CMD: shift 8 bits of D0 MSB-first. On bit 8, decode.
    - 03h: ADDR, single.
    - 0Bh: ADDR, single, then FAST_DUMMY.
    - 02h: ADDR, single write.
    - 6Bh: ADDR, single, then QUAD_DUMMY, quad read.
    - 32h: ADDR, single, then quad write.
    - EBh: ADDR quad (nibbles D3..D0), then QUAD_DUMMY, quad read.
    - Any other opcode: IGNORE.
  - ADDR: ADDR_BITS bits (single) or ADDR_BITS/4 nibbles (EBh). The low RAM_LEN_BITS are latched as ptr; upper bits are discarded.
  - DUMMY: count sample events to the dummy count, then READ.
  - READ:
    - Single mode: d_out[1] carries ram[ptr] MSB-first with oe=0010.
    - Quad mode: d_out carries high nibble then low nibble with oe=1111.
  - WRITE:
    - Data is shifted into an 8-bit assembly register.
    - A completed byte is written to ram[ptr] on the clk after its last sample. ptr then increments.
  - IGNORE: drive nothing until deselect.
- Output timing:
  - The first read bit/nibble is driven on the shift event following the last address sample (03h) or the last dummy sample (0B/6B/EB).
  - oe is asserted on that same shift event, never earlier.
- ptr rules:
  - ptr increments after each full byte is read or written.
  - ptr wraps from 2**RAM_LEN_BITS-1 to 0.
  - Streaming continues indefinitely until deselect.
- Partial bytes:
  - Deselect mid-write discards the partial byte. Completed bytes persist.
  - Deselect mid-address or mid-dummy leaves RAM untouched.
- Read-during-write: if a write commit and the fetch for the next read byte target the same address, the fetch returns the new data. The commit is ordered first.
- Debug port:
  - debug_data <= ram[debug_addr] each clk (1-cycle latency).
  - Same-cycle SPI write to the same address returns old data.
- Reset mid-transaction: everything returns to reset values immediately (asynchronously). The RAM keeps its contents.

Decomposition:
- Shared package spi_periph_pkg holds:
  - opcode constants: CMD_READ=03h, CMD_FAST=0Bh, CMD_WRITE=02h, CMD_QREAD=6Bh, CMD_QWRITE=32h, CMD_QIOREAD=EBh;
  - the state enum (CMD, ADDR, DUMMY, READ, WRITE, IGNORE).
- One sub-module: spi_pin_sync, the 2-flop synchroniser with SCK rise/fall edge detect. It is instanced once for the whole pin bundle.

Test Plan:
- Single write then read: 02h addr 000005h data A5 3C, deselect; then 03h addr 000005h -> MISO returns A5 3C; debug_addr=5 gives A5 next clk, debug_addr=6 gives 3C.
- Quad write then fast read: 32h addr 00003Fh nibbles 1,2,3,4, then 6Bh addr 00003Fh.
  - -> QUAD_DUMMY=2 cycles with oe=0000, then oe=1111, nibbles 1,2 (ram[3F]=12h), then 3,4 (ram[0]=34h, wrap).
- EBh quad-I/O read of addr 000010h after writing 77h there -> address taken in 6 nibbles, 2 dummy cycles, then nibbles 7,7.
- 0Bh at addr 000001h -> 8 dummy cycles with d_oe=0, then oe=0010 and the byte MSB-first.
- Deselect after 5 data bits of an 02h write to addr 2 (previously 00h) -> ram[2] stays 00h; oe=0 within 3 clk of pad deselect.
- Unknown opcode 9Fh followed by 40 SCK cycles -> d_oe stays 0000 and RAM is unchanged. Assert rst_n low mid-6Bh read -> outputs 0 immediately; the next 03h transaction works normally.
